// File: rtl/hsv_mask_stats.sv
// hsv_mask_stats: HSV window mask with per-frame masked-pixel count and optional bounding box.
// Define HSV_MASK_BBOX_EN to enable bounding-box tracking.
module hsv_mask_stats #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic        din_sof,
    input  logic [7:0]  din_h,
    input  logic [7:0]  din_s,
    input  logic [7:0]  din_v,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        mask_valid,
    output logic        mask_out,
    output logic        frame_done,
    output logic [19:0] pix_count,
    output logic [9:0]  bbox_xmin,
    output logic [9:0]  bbox_xmax,
    output logic [9:0]  bbox_ymin,
    output logic [9:0]  bbox_ymax,
    output logic        bbox_valid
);
    localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
    logic [0:0] state;
    logic [9:0] x, y, cx, cy;
    logic [7:0] sh [6];
    logic [7:0] act [6];
    logic [7:0] th [6];
    logic take, acc, last, hin, hit0, hit;
    logic s1_valid, s1_mask, s1_acc, s1_sof, s1_last;
    logic [19:0] cnt, cnt_n;

    // A sof pixel is judged against the freshly copied shadow window.
    always_comb begin
        take = din_valid & din_sof;
        for (int i = 0; i < 6; i++) th[i] = take ? sh[i] : act[i];
        cx = din_sof ? 10'd0 : x;
        cy = din_sof ? 10'd0 : y;
        acc = take | (state == ACTIVE);
        last = acc && cx == 10'(IMG_W - 1) && cy == 10'(IMG_H - 1);
        hin = th[0] <= th[1] ? (din_h >= th[0] && din_h <= th[1]) : (din_h >= th[0] || din_h <= th[1]);
        hit0 = hin && din_s >= th[2] && din_s <= th[3] && din_v >= th[4] && din_v <= th[5];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            for (int i = 0; i < 6; i++) begin
                sh[i] <= (i % 2 == 1) ? 8'hff : 8'h00;
                act[i] <= (i % 2 == 1) ? 8'hff : 8'h00;
            end
            s1_valid <= 1'b0;
            s1_mask <= 1'b0;
            s1_acc <= 1'b0;
            s1_sof <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (cfg_we && cfg_addr == 3'(i)) sh[i] <= cfg_data;
                if (take) act[i] <= sh[i];
            end
            s1_valid <= din_valid;
            s1_mask <= din_valid & hit0;
            s1_acc <= din_valid & acc;
            s1_sof <= take;
            s1_last <= din_valid & last;
            if (din_valid && acc) begin
                state <= last ? IDLE : ACTIVE;
                x <= (last || cx == 10'(IMG_W - 1)) ? 10'd0 : cx + 10'd1;
                y <= last ? 10'd0 : (cx == 10'(IMG_W - 1) ? cy + 10'd1 : cy);
            end
        end
    end

    assign hit = s1_acc & s1_mask;
    assign cnt_n = (s1_sof ? 20'd0 : cnt) + 20'(hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_valid <= 1'b0;
            mask_out <= 1'b0;
            frame_done <= 1'b0;
            pix_count <= '0;
            cnt <= '0;
        end else begin
            mask_valid <= s1_valid;
            mask_out <= s1_mask;
            frame_done <= s1_last;
            if (s1_acc) cnt <= cnt_n;
            if (s1_last) pix_count <= cnt_n;
        end
    end

`ifdef HSV_MASK_BBOX_EN
    logic [9:0] s1_x, s1_y, xmin, xmax, ymin, ymax;
    logic [9:0] xmin_b, xmax_b, ymin_b, ymax_b, xmin_n, xmax_n, ymin_n, ymax_n;
    logic any, any_b, any_n;

    always_ff @(posedge clk) begin
        s1_x <= cx;
        s1_y <= cy;
    end

    // The first hit of a frame seeds min and max regardless of the stale values.
    always_comb begin
        any_b = s1_sof ? 1'b0 : any;
        xmin_b = s1_sof ? 10'd0 : xmin;
        xmax_b = s1_sof ? 10'd0 : xmax;
        ymin_b = s1_sof ? 10'd0 : ymin;
        ymax_b = s1_sof ? 10'd0 : ymax;
        any_n = any_b | hit;
        xmin_n = (hit && (!any_b || s1_x < xmin_b)) ? s1_x : xmin_b;
        xmax_n = (hit && (!any_b || s1_x > xmax_b)) ? s1_x : xmax_b;
        ymin_n = (hit && (!any_b || s1_y < ymin_b)) ? s1_y : ymin_b;
        ymax_n = (hit && (!any_b || s1_y > ymax_b)) ? s1_y : ymax_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {any, xmin, xmax, ymin, ymax} <= '0;
            {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} <= '0;
        end else begin
            if (s1_acc) {any, xmin, xmax, ymin, ymax} <= {any_n, xmin_n, xmax_n, ymin_n, ymax_n};
            if (s1_last) begin
                bbox_valid <= any_n;
                bbox_xmin <= any_n ? xmin_n : 10'd0;
                bbox_xmax <= any_n ? xmax_n : 10'd0;
                bbox_ymin <= any_n ? ymin_n : 10'd0;
                bbox_ymax <= any_n ? ymax_n : 10'd0;
            end
        end
    end
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
    assign bbox_valid = 1'b0;
`endif
endmodule

// File: tb/tb_hsv_mask_stats.sv
// tb_hsv_mask_stats: randomized and directed bench with a frame-level reference model.
module tb_hsv_mask_stats;
    localparam int W = 4, H = 2;
`ifdef HSV_MASK_BBOX_EN
    localparam bit BB = 1'b1;
`else
    localparam bit BB = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic din_valid = 1'b0, din_sof = 1'b0, cfg_we = 1'b0;
    logic [7:0] din_h = '0, din_s = '0, din_v = '0, cfg_data = '0;
    logic [2:0] cfg_addr = '0;
    logic mask_valid, mask_out, frame_done, bbox_valid;
    logic [19:0] pix_count;
    logic [9:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

    always #5 clk = ~clk;

    hsv_mask_stats #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
        .din_h(din_h), .din_s(din_s), .din_v(din_v),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mask_valid(mask_valid), .mask_out(mask_out), .frame_done(frame_done),
        .pix_count(pix_count), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .bbox_valid(bbox_valid)
    );

    typedef struct {
        bit rs, mv, mo, fd, bv;
        int pc, x0, x1, y0, y1;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int sh[6], act[6];
    bit active;
    int n;
    int hx[$], hy[$];
    int o_pc, o_x0, o_x1, o_y0, o_y1;
    bit o_bv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit inwin(input int h, input int s, input int v);
        bit hin;
        hin = act[0] <= act[1] ? (h >= act[0] && h <= act[1]) : (h >= act[0] || h <= act[1]);
        return hin && s >= act[2] && s <= act[3] && v >= act[4] && v <= act[5];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            sh[i] = (i % 2 == 1) ? 255 : 0;
            act[i] = sh[i];
        end
        active = 0;
        n = 0;
        hx.delete();
        hy.delete();
        {o_pc, o_x0, o_x1, o_y0, o_y1} = '0;
        o_bv = 0;
    endtask

    // Frame statistics are recomputed from the list of masked coordinates.
    task automatic close_frame();
        o_pc = hx.size();
        o_bv = BB && hx.size() > 0;
        {o_x0, o_x1, o_y0, o_y1} = '0;
        if (o_bv) begin
            o_x0 = W; o_y0 = H; o_x1 = -1; o_y1 = -1;
            foreach (hx[i]) begin
                if (hx[i] < o_x0) o_x0 = hx[i];
                if (hx[i] > o_x1) o_x1 = hx[i];
                if (hy[i] < o_y0) o_y0 = hy[i];
                if (hy[i] > o_y1) o_y1 = hy[i];
            end
        end
    endtask

    task automatic step(input bit v, input bit sof, input int h, input int s, input int vv,
                        input bit we = 0, input int a = 0, input int d = 0, input bit r = 0);
        exp_t e;
        e = '{default: 0};
        rst = r; din_valid = v; din_sof = sof;
        din_h = 8'(h); din_s = 8'(s); din_v = 8'(vv);
        cfg_we = we; cfg_addr = 3'(a); cfg_data = 8'(d);
        if (r) begin
            model_reset();
            q.delete();
            e.rs = 1;
            q.push_back(e);
        end else begin
            if (v && sof) begin
                act = sh; active = 1; n = 0; hx.delete(); hy.delete();
            end
            e.mv = v;
            e.mo = v && inwin(h, s, vv);
            if (v && active) begin
                if (e.mo) begin
                    hx.push_back(n % W);
                    hy.push_back(n / W);
                end
                n++;
                if (n == W * H) begin
                    active = 0;
                    e.fd = 1;
                    close_frame();
                end
            end
            if (we && a < 6) sh[a] = d;
        end
        e.pc = o_pc; e.bv = o_bv; e.x0 = o_x0; e.x1 = o_x1; e.y0 = o_y0; e.y1 = o_y1;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("mask_valid", 32'(mask_valid), 32'(e.mv));
        if (e.mv || e.rs) chk("mask_out", 32'(mask_out), 32'(e.mo));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("pix_count", 32'(pix_count), 32'(e.pc));
        chk("bbox_valid", 32'(bbox_valid), 32'(e.bv));
        chk("bbox_xmin", 32'(bbox_xmin), 32'(e.x0));
        chk("bbox_xmax", 32'(bbox_xmax), 32'(e.x1));
        chk("bbox_ymin", 32'(bbox_ymin), 32'(e.y0));
        chk("bbox_ymax", 32'(bbox_ymax), 32'(e.y1));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int a, input int d);
        step(0, 0, 0, 0, 0, 1, a, d);
    endtask

    function automatic int r8();
        return int'($urandom_range(0, 255));
    endfunction

    task automatic rand_frame(input int np);
        for (int i = 0; i < np; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1, i == 0, r8(), r8(), r8());
        end
    endtask

    initial begin
        int hs[4];
        hs = '{10, 100, 230, 20};
        model_reset();
        q.push_back('{default: 0});
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        rand_frame(8);
        idle(3);
        chk("pass_all_count", 32'(pix_count), 32'd8);
        chk("pass_all_xmax", 32'(bbox_xmax), BB ? 32'd3 : 32'd0);
        chk("pass_all_ymax", 32'(bbox_ymax), BB ? 32'd1 : 32'd0);

        cfg(0, 200);
        cfg(1, 20);
        for (int i = 0; i < 8; i++) step(1, i == 0, i < 4 ? hs[i] : r8(), r8(), r8());
        idle(3);

        cfg(0, 0);
        cfg(1, 255);
        cfg(4, 77);
        cfg(5, 77);
        for (int i = 0; i < 8; i++) step(1, i == 0, r8(), r8(), i == 6 ? 77 : int'($urandom_range(0, 76)));
        idle(3);
        chk("single_count", 32'(pix_count), 32'd1);
        chk("single_valid", 32'(bbox_valid), 32'(BB));
        chk("single_xmin", 32'(bbox_xmin), BB ? 32'd2 : 32'd0);
        chk("single_ymin", 32'(bbox_ymin), BB ? 32'd1 : 32'd0);
        for (int i = 0; i < 8; i++) step(1, i == 0, r8(), r8(), 0);
        idle(3);
        chk("reject_count", 32'(pix_count), 32'd0);
        chk("reject_valid", 32'(bbox_valid), 32'd0);

        cfg(4, 0);
        cfg(5, 255);
        rand_frame(5);
        rand_frame(8);
        idle(3);
        chk("restart_count", 32'(pix_count), 32'd8);

        for (int i = 0; i < 8; i++)
            step(1, i == 0, r8(), r8(), r8(), i == 3, 4, 128);
        rand_frame(8);
        idle(3);

        cfg(3, 10);
        rand_frame(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        rand_frame(8);
        idle(3);
        chk("after_reset_count", 32'(pix_count), 32'd8);

        for (int c = 0; c < 400; c++) begin
            bit we;
            we = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 3) == 0)
                step(0, 0, r8(), r8(), r8(), we, int'($urandom_range(0, 7)), r8());
            else
                step(1, $urandom_range(0, 11) == 0, r8(), r8(), r8(), we, int'($urandom_range(0, 7)), r8());
            if ($urandom_range(0, 199) == 0) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hsv_mask_stats.md
HSV_MASK_STATS -- requirements
Module: hsv_mask_stats

Interface
REQ-001 SHALL have parameter IMG_W, default 640: pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480: lines per frame.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port din_valid, input, 1 bit: HSV pixel qualifier.
REQ-006 SHALL have port din_sof, input, 1 bit: first pixel of frame, meaningful only with din_valid.
REQ-007 SHALL have ports din_h, din_s and din_v, input, 8 bits each: hue, saturation and value from the RGB-to-HSV stage.
REQ-008 SHALL have port cfg_we, input, 1 bit: threshold write strobe.
REQ-009 SHALL have port cfg_addr, input, 3 bits: threshold select.
REQ-010 SHALL have port cfg_data, input, 8 bits: threshold value.
REQ-011 SHALL have port mask_valid, output, 1 bit: mask_out qualifier.
REQ-012 SHALL have port mask_out, output, 1 bit: 1 = pixel inside HSV window.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame statistics are updated.
REQ-014 SHALL have port pix_count, output, 20 bits: masked-pixel count of the last complete frame.
REQ-015 SHALL have ports bbox_xmin, bbox_xmax, bbox_ymin and bbox_ymax, output, 10 bits each: bounding box of masked pixels.
REQ-016 SHALL have port bbox_valid, output, 1 bit: bounding box holds at least one pixel.

Function
REQ-017 SHALL hold six 8-bit active thresholds: h_lo, h_hi, s_lo, s_hi, v_lo and v_hi.
REQ-018 SHALL write shadow registers on cfg_we, with cfg_addr 0..5 selecting the threshold in REQ-017 order; addr 6..7 SHALL be ignored.
REQ-019 SHALL copy shadow to active thresholds only on an accepted din_sof pixel, before that pixel is evaluated; the window SHALL never change mid-frame.
REQ-020 SHALL compute hue-in-window as h_lo<=h<=h_hi when h_lo<=h_hi, else as h>=h_lo or h<=h_hi (hue wrap-around).
REQ-021 SHALL set mask_out to hue-in-window AND s_lo<=s<=s_hi AND v_lo<=v<=v_hi, with all compares unsigned and inclusive.
REQ-022 SHALL assert mask_valid exactly 2 cycles after each din_valid, with no gaps or bubbles, regardless of state.
REQ-023 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on din_valid&din_sof; ACTIVE->IDLE on the valid pixel with x==IMG_W-1 and y==IMG_H-1.
REQ-024 SHALL, in ACTIVE, count x per valid pixel; x SHALL wrap IMG_W-1->0 with y incremented; a sof pixel SHALL be x=0, y=0.
REQ-025 SHALL, in IDLE, evaluate non-sof valid pixels for mask_out only, with no accumulation.
REQ-026 SHALL restart x, y, count and bbox on din_sof while ACTIVE (mid-frame), discarding the partial frame with no frame_done.
REQ-027 SHALL increment a 20-bit accumulator per masked pixel of the frame and update min/max of x and y.
REQ-028 SHALL, on the cycle mask_valid of the last pixel is high, latch accumulators to the outputs and pulse frame_done on that same cycle.
REQ-029 SHALL, for a frame with zero masked pixels, latch bbox_valid=0, all bbox ports=0 and pix_count=0.
REQ-030 SHALL give cfg_we and din_sof in the same cycle a new shadow value that first takes effect at the next sof.

Reset
REQ-031 SHALL, on rst, set FSM=IDLE, x=y=0, clear accumulators and the pipeline, and drive mask_valid=0, mask_out=0, frame_done=0, pix_count=0, bbox_*=0 and bbox_valid=0.
REQ-032 SHALL, on rst, set shadow and active thresholds to h_lo=0, h_hi=255, s_lo=0, s_hi=255, v_lo=0 and v_hi=255 (pass-all).
REQ-033 SHALL, on rst mid-frame, abort the frame with no frame_done; in-flight mask_valid SHALL be dropped.

Configuration
REQ-034 SHALL implement bounding-box tracking when macro HSV_MASK_BBOX_EN is defined, giving REQ-015/016/027/029 bbox behaviour.
REQ-035 SHALL, without HSV_MASK_BBOX_EN, omit min/max logic and tie bbox_* and bbox_valid to 0; pix_count and frame_done SHALL be unchanged.

Verification (IMG_W=4, IMG_H=2)
REQ-036 SHALL cover: reset, then 8 valid pixels with sof on the first, any HSV -> 8 mask_out=1, frame_done once, pix_count=8, bbox (0,3,0,1).
REQ-037 SHALL cover: h_lo=200, h_hi=20 written, then frame with h={10,100,230,20,...} -> mask_out 1,0,1,1 on the first line.
REQ-038 SHALL cover: single masked pixel at x=2, y=1 -> pix_count=1, bbox (2,2,1,1), bbox_valid=1; all-reject frame -> bbox_valid=0, pix_count=0.
REQ-039 SHALL cover: sof reasserted after 5 pixels -> no frame_done; next full frame reports only its own counts.
REQ-040 SHALL cover: cfg_we of v_lo=128 at pixel 3 of a frame -> current frame unaffected; next frame rejects v<128.
REQ-041 SHALL cover: rst asserted at pixel 4 -> outputs 0, no frame_done, thresholds pass-all.
